// File: rtl/pipeline1_fetch.sv
// Instruction-fetch stage: owns the PC, issues single outstanding memory reads,
// buffers returned words in a small prefetch FIFO and feeds one instruction per cycle.
module pipeline1_fetch #(
    parameter int unsigned                  INSTR_WIDTH = 32,
    parameter int unsigned                  PC_WIDTH    = 16,
    parameter logic [PC_WIDTH-1:0]          RESET_PC    = '0,
    parameter int unsigned                  FIFO_DEPTH  = 2,
    parameter logic [INSTR_WIDTH-1:0]       NOP_INSTR   = '0
) (
    input  logic                   clk_in,
    input  logic                   RST,
    input  logic                   stall,
    input  logic                   branch_en,
    input  logic [PC_WIDTH-1:0]    branch_addr,
    output logic                   mem_req,
    output logic [PC_WIDTH-1:0]    mem_addr,
    input  logic                   mem_ack,
    input  logic [INSTR_WIDTH-1:0] mem_data,
    output logic [INSTR_WIDTH-1:0] instr,
    output logic [PC_WIDTH-1:0]    pc_out,
    output logic                   instr_valid
);

    localparam int unsigned PtrW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CntW   = PtrW + 1;
    localparam int unsigned EntryW = PC_WIDTH + INSTR_WIDTH;

    typedef enum logic [1:0] {StIdle, StWait, StDiscard} state_e;

    state_e              state_q;
    logic [PC_WIDTH-1:0] pc_q;

    logic [EntryW-1:0]   fifo_mem [FIFO_DEPTH];
    logic [PtrW-1:0]     wr_ptr_q;
    logic [PtrW-1:0]     rd_ptr_q;
    logic [CntW-1:0]     count_q;

    logic                has_room;
    logic                fifo_empty;
    logic                push;
    logic                pop;
    logic [EntryW-1:0]   head;

    always_comb begin
        has_room   = count_q < CntW'(FIFO_DEPTH);
        fifo_empty = count_q == '0;
        // A redirect in the same cycle as an ack drops the returning word.
        push       = (state_q == StWait) && mem_ack && !branch_en;
        pop        = !branch_en && !stall && !fifo_empty;
        head       = fifo_mem[rd_ptr_q];
    end

    // Fetch FSM: at most one request in flight; DISCARD absorbs the ack of a
    // request made stale by a redirect.
    always_ff @(posedge clk_in or negedge RST) begin
        if (!RST) begin
            state_q  <= StIdle;
            pc_q     <= RESET_PC;
            mem_req  <= 1'b0;
            mem_addr <= RESET_PC;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (branch_en) begin
                        pc_q <= branch_addr;
                    end else if (has_room) begin
                        mem_req  <= 1'b1;
                        mem_addr <= pc_q;
                        state_q  <= StWait;
                    end
                end
                StWait: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        state_q <= StIdle;
                        pc_q    <= branch_en ? branch_addr : pc_q + PC_WIDTH'(1);
                    end else if (branch_en) begin
                        pc_q    <= branch_addr;
                        state_q <= StDiscard;
                    end
                end
                StDiscard: begin
                    if (branch_en) begin
                        pc_q <= branch_addr;
                    end
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        state_q <= StIdle;
                    end
                end
                default: begin
                    mem_req <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= {mem_addr, mem_data};
        end
    end

    always_ff @(posedge clk_in or negedge RST) begin
        if (!RST) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (branch_en) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
            count_q <= count_q + CntW'(push) - CntW'(pop);
        end
    end

    // Output register: redirect beats stall beats pop beats bubble.
    always_ff @(posedge clk_in or negedge RST) begin
        if (!RST) begin
            instr       <= NOP_INSTR;
            pc_out      <= '0;
            instr_valid <= 1'b0;
        end else if (branch_en) begin
            instr       <= NOP_INSTR;
            instr_valid <= 1'b0;
        end else if (stall) begin
            instr       <= instr;
            instr_valid <= instr_valid;
        end else if (!fifo_empty) begin
            pc_out      <= head[EntryW-1:INSTR_WIDTH];
            instr       <= head[INSTR_WIDTH-1:0];
            instr_valid <= 1'b1;
        end else begin
            instr       <= NOP_INSTR;
            instr_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pipeline1_fetch.sv
// Scoreboard bench for pipeline1_fetch: a memory model answers requests, expected
// {pc, instr} words are queued per scenario and a monitor checks every issued word.
module tb_pipeline1_fetch;

    logic        clk_in = 1'b0;
    logic        RST = 1'b0;
    logic        stall = 1'b0;
    logic        branch_en = 1'b0;
    logic [15:0] branch_addr = '0;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_data;
    logic [31:0] instr;
    logic [15:0] pc_out;
    logic        instr_valid;

    logic        mem_auto = 1'b1;
    logic        ack_auto = 1'b0;
    logic [31:0] data_auto = '0;
    logic        ack_man = 1'b0;
    logic [31:0] data_man = '0;

    logic [47:0] exp_q [$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          n_pop = 0;
    int          p0;

    assign mem_ack  = mem_auto ? ack_auto : ack_man;
    assign mem_data = mem_auto ? data_auto : data_man;

    pipeline1_fetch #(
        .INSTR_WIDTH(32),
        .PC_WIDTH   (16),
        .RESET_PC   (16'h0000),
        .FIFO_DEPTH (2),
        .NOP_INSTR  (32'h0)
    ) dut (
        .clk_in     (clk_in),
        .RST        (RST),
        .stall      (stall),
        .branch_en  (branch_en),
        .branch_addr(branch_addr),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_ack    (mem_ack),
        .mem_data   (mem_data),
        .instr      (instr),
        .pc_out     (pc_out),
        .instr_valid(instr_valid)
    );

    always #5 clk_in = ~clk_in;

    // Memory answers in the cycle after a request appears; word = 0x100 + address.
    always @(negedge clk_in) begin
        ack_auto  <= mem_req;
        data_auto <= 32'h100 + {16'h0, mem_addr};
    end

    task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk_in);
        #1;
    endtask

    task automatic push_exp(input logic [15:0] start, input int n);
        logic [15:0] a;
        for (int i = 0; i < n; i++) begin
            a = start + 16'(i);
            exp_q.push_back({a, 32'h100 + {16'h0, a}});
        end
    endtask

    task automatic do_reset(input logic st);
        RST       = 1'b0;
        stall     = st;
        branch_en = 1'b0;
        ack_man   = 1'b0;
        mem_auto  = 1'b1;
        tick(2);
        RST = 1'b1;
        exp_q.delete();
    endtask

    // Monitor: every edge that should pop a word (no reset, stall or redirect)
    // and yields instr_valid consumes one scoreboard entry.
    task automatic monitor();
        logic        st_s, br_s, rst_s;
        logic [47:0] e;
        forever begin
            @(posedge clk_in);
            st_s  = stall;
            br_s  = branch_en;
            rst_s = RST;
            #1;
            if (rst_s && RST && !st_s && !br_s && instr_valid) begin
                n_pop++;
                if (exp_q.size() == 0) begin
                    check("unexpected_word", {pc_out, instr}, 48'hFFFF_FFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    check("scoreboard_word", {pc_out, instr}, e);
                end
            end
        end
    endtask

    initial begin
        fork
            monitor();
        join_none

        // Reset state
        RST = 1'b0;
        #12;
        check("rst_mem_req", 48'(mem_req), 48'd0);
        check("rst_mem_addr", 48'(mem_addr), 48'd0);
        check("rst_instr", 48'(instr), 48'd0);
        check("rst_pc_out", 48'(pc_out), 48'd0);
        check("rst_valid", 48'(instr_valid), 48'd0);

        // Straight-line fetch 0x100, 0x101, 0x102...
        do_reset(1'b0);
        push_exp(16'h0000, 20);
        p0 = n_pop;
        tick(2);
        check("seq_bubble", 48'(instr_valid), 48'd0);
        tick(1);
        check("seq_first", {pc_out, instr}, {16'h0000, 32'h100});
        check("seq_first_valid", 48'(instr_valid), 48'd1);
        tick(12);
        check("seq_progress", 48'(n_pop - p0 >= 3), 48'd1);

        // Stall from reset: FIFO fills, requests stop, then two words back-to-back
        do_reset(1'b1);
        tick(8);
        check("stall_valid", 48'(instr_valid), 48'd0);
        check("stall_req_idle", 48'(mem_req), 48'd0);
        check("stall_instr", 48'(instr), 48'd0);
        push_exp(16'h0000, 20);
        stall = 1'b0;
        tick(1);
        check("release_w0", {15'd0, instr_valid, pc_out, instr}, {15'd0, 1'b1, 16'h0000, 32'h100});
        tick(1);
        check("release_w1", {15'd0, instr_valid, pc_out, instr}, {15'd0, 1'b1, 16'h0001, 32'h101});

        // Redirect while a request is outstanding; late ack must be discarded
        do_reset(1'b0);
        mem_auto = 1'b0;
        for (int i = 0; i < 10 && !mem_req; i++) tick(1);
        check("br_req_seen", 48'(mem_req), 48'd1);
        branch_en   = 1'b1;
        branch_addr = 16'h0040;
        tick(1);
        branch_en = 1'b0;
        check("br_discard_req", 48'(mem_req), 48'd1);
        check("br_bubble", 48'(instr_valid), 48'd0);
        tick(2);
        ack_man  = 1'b1;
        data_man = 32'hDEAD;
        tick(1);
        ack_man  = 1'b0;
        mem_auto = 1'b1;
        check("br_discard_done", 48'(mem_req), 48'd0);
        push_exp(16'h0040, 20);
        p0 = n_pop;
        tick(1);
        check("br_new_addr", {31'd0, mem_req, mem_addr}, {31'd0, 1'b1, 16'h0040});
        tick(8);
        check("br_progress", 48'(n_pop - p0 >= 2), 48'd1);

        // PC wrap from 0xFFFF to 0x0000
        do_reset(1'b0);
        branch_en   = 1'b1;
        branch_addr = 16'hFFFF;
        tick(1);
        branch_en = 1'b0;
        push_exp(16'hFFFF, 20);
        p0 = n_pop;
        tick(10);
        check("wrap_progress", 48'(n_pop - p0 >= 2), 48'd1);

        // Branch together with stall: bubble, flush, fetch from target
        do_reset(1'b0);
        push_exp(16'h0000, 20);
        tick(3);
        stall = 1'b1;
        tick(6);
        check("bs_frozen", {15'd0, instr_valid, pc_out, instr}, {15'd0, 1'b1, 16'h0000, 32'h100});
        check("bs_full_no_req", 48'(mem_req), 48'd0);
        branch_en   = 1'b1;
        branch_addr = 16'h0080;
        tick(1);
        check("bs_bubble", {15'd0, instr_valid, 32'd0, instr}, 48'd0);
        branch_en = 1'b0;
        stall     = 1'b0;
        exp_q.delete();
        push_exp(16'h0080, 20);
        p0 = n_pop;
        tick(10);
        check("bs_progress", 48'(n_pop - p0 >= 2), 48'd1);

        // Reset during an outstanding request; stale ack after release ignored
        do_reset(1'b0);
        mem_auto = 1'b0;
        for (int i = 0; i < 10 && !mem_req; i++) tick(1);
        check("mid_req_seen", 48'(mem_req), 48'd1);
        RST = 1'b0;
        #1;
        check("mid_rst_req_drop", 48'(mem_req), 48'd0);
        tick(1);
        RST      = 1'b1;
        ack_man  = 1'b1;
        data_man = 32'hBAD0;
        exp_q.delete();
        tick(1);
        ack_man = 1'b0;
        check("mid_restart", {31'd0, mem_req, mem_addr}, {31'd0, 1'b1, 16'h0000});
        check("mid_nop", {15'd0, instr_valid, 32'd0, instr}, 48'd0);
        mem_auto = 1'b1;
        push_exp(16'h0000, 20);
        p0 = n_pop;
        tick(10);
        check("mid_progress", 48'(n_pop - p0 >= 2), 48'd1);

        tick(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
